// File: rtl/ram_param_clear_pkg.sv
// Shared types, defaults and helpers for the parametrised clear-able RAM.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LANE_WIDTH = 8;
    localparam logic [DEF_DATA_WIDTH-1:0] DEF_CLEAR_VALUE = '0;

    // Upper bound on word width handled by the generic merge helper.
    localparam int MAX_DW    = 1024;
    localparam int MAX_LANES = 1024;

    function automatic int lane_count(input int dw, input int lw);
        return dw / lw;
    endfunction

    // Per-lane select between the stored word and new data; callers
    // zero-extend to MAX_DW and truncate the result back to their width.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0]    old_w,
        input logic [MAX_DW-1:0]    new_w,
        input logic [MAX_LANES-1:0] en,
        input int                   lw
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int b = 0; b < MAX_DW; b++) begin
            if (en[b / lw]) res[b] = new_w[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_param_clear_if.sv
// Datapath-to-memory access bus: address/data/strobes in, read data and status out.
// Latency: n/a (wires only).
// Backpressure: busy high means accesses are dropped by the memory.
interface ram_param_clear_if
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH
);
    localparam int LANES = lane_count(DATA_WIDTH, LANE_WIDTH);

    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] in;
    logic                  write;
    logic [LANES-1:0]      lane_en;
    logic                  read;
    logic                  clear;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_valid;
    logic                  busy;

    modport master (
        output address, in, write, lane_en, read, clear,
        input  out, out_valid, busy
    );

    modport slave (
        input  address, in, write, lane_en, read, clear,
        output out, out_valid, busy
    );

endinterface

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: owns state and sweep pointer, drives the array write-port mux.
// Latency: sweep takes 2**ADDR_WIDTH falling edges after reset release or a clear request.
// Backpressure: busy_o high while sweeping; accept_o low so accesses are dropped.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(DEF_CLEAR_VALUE)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  accept_o,
    output logic                  clr_sel_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic [DATA_WIDTH-1:0] clr_data_o
);
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;

    // Sweep the pointer through every address, then idle in READY until a clear request.
    always_ff @(negedge clock) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (&ptr_q) state_q <= ST_READY;
                end
                default: begin
                    if (clear_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_sel_o  = busy_o;
    // Reset held keeps the array untouched, so both write sources are gated by it.
    assign clr_we_o   = reset_n && busy_o;
    assign accept_o   = reset_n && !busy_o && !clear_i;
    assign clr_addr_o = ptr_q;
    assign clr_data_o = CLEAR_VALUE;

endmodule

// File: rtl/ram_param_clear.sv
// Single-port RAM with lane-masked write-first access and a hardware clear sweep.
// Latency: read data and out_valid registered on the same falling edge that samples read.
// Backpressure: accesses are silently dropped while busy (clear sweep) or on a clear request edge.
module ram_param_clear
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    LANE_WIDTH  = DEF_LANE_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(DEF_CLEAR_VALUE)
) (
    input  logic               clock,
    input  logic               reset_n,
    ram_param_clear_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = lane_count(DATA_WIDTH, LANE_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;

    logic                  busy, accept, clr_sel, clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_data;

    logic [DATA_WIDTH-1:0] rd_word, merged, wr_data;
    logic [LANES-1:0]      lane_sel;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;

    ram_clear_fsm #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .CLEAR_VALUE (CLEAR_VALUE)
    ) u_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (bus.clear),
        .busy_o     (busy),
        .accept_o   (accept),
        .clr_sel_o  (clr_sel),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .clr_data_o (clr_data)
    );

    // Merged word serves both the write data and the write-first read result;
    // with write low every lane keeps the stored value.
    assign rd_word  = mem_q[bus.address];
    assign lane_sel = bus.write ? bus.lane_en : '0;
    assign merged   = DATA_WIDTH'(lane_merge(MAX_DW'(rd_word), MAX_DW'(bus.in),
                                             MAX_LANES'(lane_sel), LANE_WIDTH));

    assign wr_en   = clr_sel ? clr_we   : (accept && bus.write);
    assign wr_addr = clr_sel ? clr_addr : bus.address;
    assign wr_data = clr_sel ? clr_data : merged;

    // Single write port shared between the sweep and datapath writes.
    always_ff @(negedge clock) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Load read data on an accepted read; otherwise hold data and drop valid.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (accept && bus.read) begin
            out_d       = merged;
            out_valid_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(negedge clock) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_ram_param_clear.sv
// Scoreboard bench for ram_param_clear at 64 x 16 words, 8-bit lanes.
// Latency: expects read data on the edge that samples read.
// Backpressure: tracks busy windows and expects accesses to be dropped there.
module tb_ram_param_clear;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    ram_param_clear_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .LANE_WIDTH(8)) bus ();

    ram_param_clear #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (4),
        .LANE_WIDTH (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    logic [63:0] model [16];
    bit          model_ready = 1'b0;
    logic [63:0] sb_q [$];
    logic [63:0] last_out = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tb_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                             input logic [7:0] en);
        logic [63:0] r;
        for (int i = 0; i < 8; i++)
            r[i*8 +: 8] = en[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction

    // Drive one edge worth of stimulus, update the model, then check outputs after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic clr, input logic [3:0] addr,
                         input logic [63:0] data, input logic [7:0] lanes);
        logic        exp_vld;
        logic [63:0] nw;
        logic [63:0] e;
        bus.write   = wr;
        bus.read    = rd;
        bus.clear   = clr;
        bus.address = addr;
        bus.in      = data;
        bus.lane_en = lanes;
        exp_vld     = 1'b0;
        if (reset_n && model_ready) begin
            if (clr) begin
                model_ready = 1'b0;
            end else begin
                nw = tb_merge(model[addr], data, wr ? lanes : 8'h00);
                if (wr) model[addr] = nw;
                if (rd) begin
                    sb_q.push_back(nw);
                    exp_vld = 1'b1;
                end
            end
        end
        if (!reset_n) last_out = '0;
        @(negedge clock);
        #1;
        check_eq("out_valid", 64'(bus.out_valid), 64'(exp_vld));
        if (bus.out_valid) begin
            check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("out", bus.out, e);
                last_out = e;
            end
        end else begin
            check_eq("out_hold", bus.out, last_out);
        end
    endtask

    // Run idle (or ignored-read) edges until busy drops; the sweep must take 16 edges.
    task automatic wait_clear(input logic rd, input logic [3:0] addr);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            cycle(1'b0, rd, 1'b0, addr, 64'h0, 8'h00);
            n++;
        end
        check_eq("busy_edges", 64'(n), 64'd16);
        if (!bus.busy) begin
            model_ready = 1'b1;
            for (int i = 0; i < 16; i++) model[i] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.write = 1'b0; bus.read = 1'b0; bus.clear = 1'b0;
        bus.address = '0; bus.in = '0; bus.lane_en = '0;
        for (int i = 0; i < 16; i++) model[i] = 'x;

        // Reset state.
        reset_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        check_eq("rst_busy", 64'(bus.busy), 64'd1);
        check_eq("rst_out", bus.out, 64'h0);
        reset_n = 1'b1;
        wait_clear(1'b0, 4'd0);

        // Every location reads back the clear value.
        for (int a = 0; a < 16; a++)
            cycle(1'b0, 1'b1, 1'b0, 4'(a), 64'h0, 8'h00);

        // Lane-masked overwrite, plus a zero-mask write that must change nothing.
        cycle(1'b1, 1'b0, 1'b0, 4'd3, 64'h1122334455667788, 8'hFF);
        cycle(1'b1, 1'b0, 1'b0, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        cycle(1'b1, 1'b0, 1'b0, 4'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 4'd3, 64'h0, 8'h00);
        check_eq("lane_mask", bus.out, 64'h11223344AAAAAAAA);

        // Write-first read on the same edge.
        cycle(1'b1, 1'b0, 1'b0, 4'd5, 64'h0000000012345678, 8'hFF);
        cycle(1'b1, 1'b1, 1'b0, 4'd5, 64'hDEADBEEF00000000, 8'hF0);
        check_eq("fwd", bus.out, 64'hDEADBEEF12345678);
        cycle(1'b0, 1'b1, 1'b0, 4'd5, 64'h0, 8'h00);

        // Read then drop read: data holds, valid falls.
        cycle(1'b1, 1'b0, 1'b0, 4'd7, 64'hCAFEF00D01234567, 8'hFF);
        cycle(1'b0, 1'b1, 1'b0, 4'd7, 64'h0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 4'd7, 64'h0, 8'h00);
        check_eq("hold_out", bus.out, 64'hCAFEF00D01234567);

        // Clear request beats a simultaneous write; reads during the sweep are ignored.
        cycle(1'b1, 1'b0, 1'b0, 4'd2, 64'h5555555555555555, 8'hFF);
        cycle(1'b1, 1'b0, 1'b1, 4'd2, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        wait_clear(1'b1, 4'd2);
        cycle(1'b0, 1'b1, 1'b0, 4'd2, 64'h0, 8'h00);
        check_eq("cleared", bus.out, 64'h0);
        cycle(1'b0, 1'b1, 1'b0, 4'd7, 64'h0, 8'h00);

        // Reset at sweep edge 6 restarts the full sweep.
        cycle(1'b0, 1'b0, 1'b1, 4'd0, 64'h0, 8'h00);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        reset_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 64'h0, 8'h00);
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd1);
        reset_n = 1'b1;
        wait_clear(1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b0, 4'd9, 64'h0123456789ABCDEF, 8'h3C);
        cycle(1'b0, 1'b1, 1'b0, 4'd9, 64'h0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_param_clear.md
# ram_param_clear

Parametrised synchronous single-port RAM, successor to the fixed 256x64 data memory. It adds configurable width and depth, byte-lane write masking, write-first read-during-write, an explicit read strobe with `out_valid`, and a hardware clear sequencer. The clear sequencer sweeps the array to a known value after reset or on request. It sits between the datapath and memory address/data buses and keeps the memory convention of acting on the falling clock edge.

## Interface
- `DATA_WIDTH`, 64, word width in bits; must be a multiple of `LANE_WIDTH`.
- `ADDR_WIDTH`, 8, address width; `DEPTH` = 2**`ADDR_WIDTH` words (derived, not overridable).
- `LANE_WIDTH`, 8, bits per write lane; `LANES` = `DATA_WIDTH`/`LANE_WIDTH`.
- `CLEAR_VALUE`, 0, word value written to every location during a clear sweep.

Ports:
- `clock`  in  1  single clock; all state updates on the negative edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the negative edge of `clock`.
- `address`  in  `ADDR_WIDTH`  word address for read and write.
- `in`  in  `DATA_WIDTH`  write data.
- `write`  in  1  write enable.
- `lane_en`  in  `LANES`  per-lane write mask; bit i covers `in[i*LANE_WIDTH +: LANE_WIDTH]`.
- `read`  in  1  read strobe.
- `clear`  in  1  request a full clear sweep (level; sampled only in READY).
- `out`  out  `DATA_WIDTH`  registered read data.
- `out_valid`  out  1  `out` was updated by the previous edge's read.
- `busy`  out  1  clear sweep in progress; accesses are ignored.

## Operation
- States: CLEAR, READY. Registered clear pointer `ptr` is `ADDR_WIDTH` bits wide.
- Reset (`reset_n`=0 at an edge): state goes to CLEAR, `ptr` to 0, `out` to 0, `out_valid` to 0, and `busy` to 1. Array contents are untouched while reset is held.
- CLEAR, per edge with `reset_n`=1: write `CLEAR_VALUE` to mem[`ptr`] and increment `ptr`. At the edge that writes `ptr`=`DEPTH`-1, go to READY and wrap `ptr` to 0.
- CLEAR ignores `write`, `read` and `clear`. `out` holds its value and `out_valid` is 0.
- READY with `clear`=1: go to CLEAR with `ptr` at 0. That edge drops `write` and `read` (clear has priority) and sets `out_valid` to 0.
- READY write (`write`=1): for each set bit of `lane_en`, update that lane of mem[`address`]. Clear lanes keep their old value. `lane_en`=0 means no change.
- READY read (`read`=1): `out` is loaded with mem[`address`] and `out_valid` is set to 1.
- Read and write on the same edge (same address by construction) are write-first. `out` receives the merged word, meaning old lanes where `lane_en`=0 and `in` lanes where it is 1.
- `read`=0: `out` holds its value and `out_valid` is set to 0.
- Reset asserted mid-sweep restarts the sweep from address 0 once reset releases.

## Timing
- Read latency is one falling edge: `out`/`out_valid` update at the same edge that samples `read`.
- A write is visible to a read on the same edge (forwarded) and on every later edge.
- Clear sweep takes exactly `DEPTH` edges with `reset_n`=1. `busy` is 1 through the edge that writes address `DEPTH`-1 and is 0 after it. The first access is accepted at edge `DEPTH`+1.
- `busy` is a decode of the registered state; no combinational path runs from inputs to any output.

## Structure
- Package `ram_pkg` holds:
  - the state enum (CLEAR, READY);
  - lane-count and merge helper functions;
  - default values for `DATA_WIDTH`, `ADDR_WIDTH`, `LANE_WIDTH` and `CLEAR_VALUE`.
- One sub-module, `ram_clear_fsm`, owns the state, `ptr` and `busy`. It drives the internal write-port mux select, address and data.
- The top level holds the array, the lane merge, and the `out`/`out_valid` registers.

## Test plan
Configuration for all scenarios: `DATA_WIDTH`=64, `ADDR_WIDTH`=4, `LANE_WIDTH`=8.
- Release reset and hold idle inputs -> `busy`=1 for 16 edges, then 0. Reading addresses 0..15 returns 0x0 each with `out_valid`=1.
- Write 0x1122334455667788 at address 3 with `lane_en`=0xFF, then write 0xAAAAAAAAAAAAAAAA at address 3 with `lane_en`=0x0F -> read of address 3 returns 0x11223344AAAAAAAA.
- Same-edge write 0xDEADBEEF00000000 with `lane_en`=0xF0 and read at address 5 (holding 0x0000000012345678) -> `out`=0xDEADBEEF12345678 at that edge.
- Read at address 7, then drop `read` -> `out` holds its value and `out_valid` is 1 then 0.
- Assert `clear` in READY together with a write of 0xFF..FF at address 2 -> the write is dropped, `busy`=1 for 16 edges, then address 2 reads 0x0.
- Pulse `reset_n` low at sweep edge 6 -> the sweep restarts and `busy` stays high for a full 16 edges after release.
